// File: rtl/pit_wb_regbus.sv
// pit_wb_regbus: Wishbone slave front end for a bank of PIT-style registers
// Bus side: wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i in, wb_dat_o/wb_ack_o/wb_err_o out.
// Register side: reg_wr_stb/reg_wr_data/reg_wr_sel out, reg_rd_data in (register i at [i*D_WIDTH +: D_WIDTH]).
module pit_wb_regbus #(
  parameter int D_WIDTH     = 16,
  parameter int A_WIDTH     = 3,
  parameter int S_WIDTH     = D_WIDTH / 8,
  parameter int NUM_REGS    = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic [A_WIDTH-1:0]          wb_adr_i,
  input  logic [D_WIDTH-1:0]          wb_dat_i,
  input  logic [S_WIDTH-1:0]          wb_sel_i,
  input  logic                        wb_we_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  output logic [D_WIDTH-1:0]          wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic [NUM_REGS-1:0]         reg_wr_stb,
  output logic [D_WIDTH-1:0]          reg_wr_data,
  output logic [S_WIDTH-1:0]          reg_wr_sel,
  input  logic [NUM_REGS*D_WIDTH-1:0] reg_rd_data
);
  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_e;
  localparam logic [3:0] WLAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0] adr_q, adr_d;
  logic we_q, we_d;
  logic [S_WIDTH-1:0] sel_q, sel_d;
  logic [D_WIDTH-1:0] dat_q, dat_d, rdat_q, rdat_d, rsel;
  logic ack_q, ack_d, err_q, err_d, accept, hit, term;
  logic [NUM_REGS-1:0] stb_q, stb_d, onehot;
  always_comb begin
    accept = state_q == IDLE && wb_cyc_i && wb_stb_i;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = accept ? (WAIT_STATES > 0 ? WAIT : TERM) : IDLE;
        cnt_d = '0;
      end
      WAIT: begin
        state_d = !wb_cyc_i ? IDLE : (cnt_q == WLAST ? TERM : WAIT);
        cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    adr_d = accept ? wb_adr_i : adr_q;
    we_d = accept ? wb_we_i : we_q;
    sel_d = accept ? wb_sel_i : sel_q;
    dat_d = accept ? wb_dat_i : dat_q;
    hit = 32'(adr_d) < NUM_REGS;
    onehot = '0;
    rsel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (adr_d == A_WIDTH'(i)) begin
        onehot[i] = 1'b1;
        rsel = reg_rd_data[i*D_WIDTH +: D_WIDTH];
      end
    // Outputs are registered on the edge that enters TERM, so read data is
    // sampled in the last cycle before TERM and picks up late register updates.
    term = state_d == TERM;
    ack_d = term && hit;
    err_d = term && !hit;
    stb_d = (term && hit && we_d && |sel_d) ? onehot : '0;
    rdat_d = (term && hit && !we_d) ? rsel : '0;
  end
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      adr_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      stb_q <= '0;
      rdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      we_q <= we_d;
      sel_q <= sel_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
      err_q <= err_d;
      stb_q <= stb_d;
      rdat_q <= rdat_d;
    end
  end
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = rdat_q;
  assign reg_wr_stb = stb_q;
  assign reg_wr_data = dat_q;
  assign reg_wr_sel = sel_q;
endmodule

// File: tb/tb_pit_wb_regbus.sv
// tb_pit_wb_regbus: randomized and directed checks of pit_wb_regbus at WAIT_STATES 0, 3 and 4
module tb_pit_wb_regbus;
  logic wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;
  logic rst[3], we[3], cyc[3], stb[3], ack[3], err[3];
  logic [2:0] adr[3];
  logic [15:0] dat[3], dato[3], wdat[3];
  logic [1:0] sel[3], wsel[3];
  logic [4:0] wstb[3];
  logic [79:0] rd[3];
  logic [15:0] regs[3][8];
  int checks = 0, failures = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pit_wb_regbus #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 4))) u_dut (
      .wb_clk(wb_clk), .wb_rst(rst[g]), .wb_adr_i(adr[g]), .wb_dat_i(dat[g]),
      .wb_sel_i(sel[g]), .wb_we_i(we[g]), .wb_cyc_i(cyc[g]), .wb_stb_i(stb[g]),
      .wb_dat_o(dato[g]), .wb_ack_o(ack[g]), .wb_err_o(err[g]), .reg_wr_stb(wstb[g]),
      .reg_wr_data(wdat[g]), .reg_wr_sel(wsel[g]), .reg_rd_data(rd[g])
    );
  end
  function automatic int ws(int k);
    return k == 0 ? 0 : (k == 1 ? 3 : 4);
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask
  task automatic quiet(int k, string tag);
    check({tag, "_ack"}, 64'(ack[k]), 0);
    check({tag, "_err"}, 64'(err[k]), 0);
    check({tag, "_stb"}, 64'(wstb[k]), 0);
    check({tag, "_dat"}, 64'(dato[k]), 0);
  endtask
  task automatic set_rd(int k, int i, logic [15:0] v);
    regs[k][i] = v;
    rd[k][i*16 +: 16] = v;
  endtask
  // One transaction: no response during the wait states, response exactly WS+1 cycles
  // after the request, then a quiet IDLE cycle. keep leaves the request asserted.
  task automatic xfer(int k, logic [2:0] a, logic w, logic [15:0] d, logic [1:0] s, bit keep, bit upd);
    logic [15:0] e_rd;
    logic [4:0] e_stb;
    bit hit;
    adr[k] = a; we[k] = w; dat[k] = d; sel[k] = s; cyc[k] = 1'b1; stb[k] = 1'b1;
    for (int c = 1; c <= ws(k); c++) begin
      tick();
      quiet(k, "wait");
      if (upd && c == 1 && a < 5) set_rd(k, int'(a), 16'($urandom));
    end
    hit = a < 5;
    e_rd = (hit && !w) ? regs[k][a] : 16'h0;
    e_stb = (hit && w && s != 0) ? 5'(1 << a) : 5'h0;
    tick();
    check("term_ack", 64'(ack[k]), 64'(hit));
    check("term_err", 64'(err[k]), 64'(!hit));
    check("term_dat", 64'(dato[k]), 64'(e_rd));
    check("term_stb", 64'(wstb[k]), 64'(e_stb));
    check("term_wdat", 64'(wdat[k]), 64'(d));
    check("term_wsel", 64'(wsel[k]), 64'(s));
    if (!keep) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
    tick();
    quiet(k, "post");
    check("hold_wdat", 64'(wdat[k]), 64'(d));
  endtask
  // Request into WS=4 wait, then cyc drop (or reset) during the second wait cycle.
  task automatic abort(int k, bit use_rst);
    adr[k] = 3'(int'($urandom_range(0, 4))); we[k] = 1'b1; sel[k] = 2'b11;
    dat[k] = 16'($urandom); cyc[k] = 1'b1; stb[k] = 1'b1;
    tick();
    tick();
    quiet(k, "abw");
    if (use_rst) rst[k] = 1'b1; else cyc[k] = 1'b0;
    tick();
    quiet(k, "ab");
    if (use_rst) begin
      check("rst_wdat", 64'(wdat[k]), 0);
      check("rst_wsel", 64'(wsel[k]), 0);
    end
    rst[k] = 1'b0; cyc[k] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      quiet(k, "abq");
    end
    stb[k] = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
      adr[k] = '0; dat[k] = '0; sel[k] = '0; rd[k] = '0;
      for (int i = 0; i < 8; i++) regs[k][i] = 16'h0;
      for (int i = 0; i < 5; i++) set_rd(k, i, 16'($urandom));
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      quiet(k, "reset");
      check("reset_wdat", 64'(wdat[k]), 0);
      check("reset_wsel", 64'(wsel[k]), 0);
      rst[k] = 1'b0;
    end
    xfer(0, 3'd2, 1'b1, 16'hA5C3, 2'b11, 0, 0);
    set_rd(1, 4, 16'h1234);
    xfer(1, 3'd4, 1'b0, 16'h0BAD, 2'b00, 0, 0);
    for (int k = 0; k < 2; k++) begin
      xfer(k, 3'd6, 1'b0, 16'h1111, 2'b11, 0, 0);
      xfer(k, 3'd6, 1'b1, 16'h2222, 2'b11, 0, 0);
    end
    xfer(0, 3'd1, 1'b1, 16'h00FE, 2'b01, 0, 0);
    xfer(0, 3'd3, 1'b1, 16'hBEEF, 2'b00, 0, 0);
    abort(2, 0);
    xfer(2, 3'd1, 1'b0, 16'h0, 2'b11, 0, 0);
    abort(2, 1);
    xfer(2, 3'd0, 1'b1, 16'h5A5A, 2'b10, 0, 0);
    xfer(1, 3'd3, 1'b0, 16'h0, 2'b11, 0, 1);
    for (int k = 0; k < 3; k++) begin
      xfer(k, 3'd0, 1'b0, 16'h0, 2'b11, 1, 0);
      xfer(k, 3'd1, 1'b0, 16'h0, 2'b11, 1, 0);
      xfer(k, 3'd2, 1'b0, 16'h0, 2'b11, 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        set_rd(k, int'($urandom_range(0, 4)), 16'($urandom));
        xfer(k, 3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 2'($urandom),
             n != 24 && $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pit_wb_regbus.md
# pit_wb_regbus

Parametrised Wishbone slave bus-interface unit that sits between the system Wishbone fabric and a bank of PIT-style peripheral registers. It replaces a bare signal-bundle connection with a real transaction engine: address decode, configurable wait states, single-cycle ack/err handshake, byte-lane write strobes and registered read data. It serves any register count or data width, so the same unit fronts every timer or channel variant.

## Interface
- D_WIDTH, 16, data bus width; multiple of 8, 8..64
- A_WIDTH, 3, word-address width
- S_WIDTH, D_WIDTH/8, byte-select width
- NUM_REGS, 5, implemented registers; 1..2**A_WIDTH
- WAIT_STATES, 0, extra cycles inserted before ack; 0..15
- wb_clk  in  1  system clock; all logic on rising edge
- wb_rst  in  1  reset: synchronous, active-high
- wb_adr_i  in  A_WIDTH  word address
- wb_dat_i  in  D_WIDTH  write data
- wb_sel_i  in  S_WIDTH  byte-lane select
- wb_we_i  in  1  1 = write, 0 = read
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_dat_o  out  D_WIDTH  read data; valid only while wb_ack_o = 1
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (unmapped address)
- reg_wr_stb  out  NUM_REGS  one-hot write pulse to register i
- reg_wr_data  out  D_WIDTH  latched write data
- reg_wr_sel  out  S_WIDTH  latched byte enables
- reg_rd_data  in  NUM_REGS*D_WIDTH  packed register contents; register i at bits [i*D_WIDTH +: D_WIDTH]

## Operation
- FSM states: IDLE, WAIT, TERM.
- IDLE: on wb_cyc_i & wb_stb_i, latch adr/we/sel/dat_i; clear wait counter; go to WAIT if WAIT_STATES > 0, else TERM.
- WAIT: counter increments each cycle; at count = WAIT_STATES-1, go to TERM. If wb_cyc_i falls: abort, go to IDLE; no ack, err or write strobe.
- TERM (exactly one cycle): if latched adr < NUM_REGS, assert wb_ack_o; otherwise assert wb_err_o. Never both. Always return to IDLE.
- Write in TERM with valid address: pulse reg_wr_stb[adr] for one cycle, but only if latched sel != 0. A write with sel = 0 still acks and produces no strobe.
- reg_wr_data and reg_wr_sel hold their last latched values between transactions.
- Read in TERM: wb_dat_o = reg_rd_data slice sampled on the IDLE→(WAIT|TERM) edge... no: sampled on the cycle before TERM (registered), so a register update landing during the wait states is reflected. wb_sel_i is ignored on reads; the full word is returned.
- Error read: wb_dat_o = 0.
- wb_dat_o = 0 whenever wb_ack_o = 0.
- Back-to-back: a request still present in the IDLE cycle after TERM starts a new transaction. The master must drop stb on ack to avoid a repeat.
- Reset in any state: state = IDLE, counter = 0. wb_ack_o, wb_err_o, reg_wr_stb and wb_dat_o = 0; reg_wr_data and reg_wr_sel = 0. An in-flight transaction is discarded without strobe.

## Timing
- Request sampled in cycle N gives ack/err in cycle N+1+WAIT_STATES.
- reg_wr_stb is coincident with wb_ack_o.
- Throughput: one transaction per 2+WAIT_STATES cycles.
- All outputs are registered; no combinational path from any input to any output.
- wb_stb_i without wb_cyc_i is ignored.

## Test plan
- WAIT_STATES=0: write 0xA5C3 to adr 2 with sel=2'b11, request at cycle 10 → ack at cycle 11; reg_wr_stb=5'b00100; reg_wr_data=0xA5C3.
- WAIT_STATES=3: read adr 4 with reg_rd_data slice 4 = 0x1234 → ack exactly 4 cycles after request; wb_dat_o=0x1234 during ack, 0 otherwise.
- Unmapped access: read and write to adr 6 (NUM_REGS=5) → wb_err_o for one cycle, wb_ack_o=0, no reg_wr_stb, wb_dat_o=0.
- Byte lanes: write sel=2'b01 → reg_wr_sel=2'b01 with strobe; write sel=2'b00 → ack with no strobe.
- Abort/reset: WAIT_STATES=4; drop wb_cyc_i in the second wait cycle → no ack/err/strobe, FSM returns to IDLE. Repeat, asserting wb_rst mid-wait → all outputs 0 next cycle.
- Back-to-back: hold stb across 3 reads at adrs 0,1,2 → acks every 2 cycles with the correct data each.
